// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package mem_arb_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int ADDR_W_DEF     = 16;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_FETCH  = 2'd1,
    ARB_DREAD  = 2'd2,
    ARB_DWRITE = 2'd3
  } arb_state_e;

  // Counter must be able to hold the value max_val itself.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and single-port memory signals between the core side and the arbiter.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_valid;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall;

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rdata, if_valid, dm_gnt, dm_rdata, dm_valid,
           mem_addr, mem_wdata, mem_we, stall
  );

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rdata, if_valid, dm_gnt, dm_rdata, dm_valid,
           mem_addr, mem_wdata, mem_we, stall
  );

endinterface

// File: rtl/arb_starve_cnt.sv
// Saturating up-counter with synchronous clear; counts consecutive denied fetch cycles.
module arb_starve_cnt #(
  parameter int CNT_W = 3,
  parameter int MAX   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_C)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: data over fetch, with a starvation limit that forces a fetch.
//   state    | meaning
//   IDLE     | no access issued last cycle
//   FETCH    | fetch read issued last cycle, instruction returns now
//   DREAD    | data read issued last cycle, load data returns now
//   DWRITE   | data write issued last cycle, nothing returns
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = cnt_width(STARVE_MAX);
  localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [DATA_W-1:0] ZERO_D     = '0;

  localparam logic [1:0] ST_IDLE   = ARB_IDLE;
  localparam logic [1:0] ST_FETCH  = ARB_FETCH;
  localparam logic [1:0] ST_DREAD  = ARB_DREAD;
  localparam logic [1:0] ST_DWRITE = ARB_DWRITE;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  starve_cnt;
  logic              force_fetch;
  logic              if_gnt_c, dm_gnt_c;
  logic              starve_inc, starve_clr;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              fetch_rsp, dread_rsp;

  arb_starve_cnt #(
    .CNT_W (CNT_W),
    .MAX   (STARVE_MAX)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (starve_inc),
    .clr (starve_clr),
    .cnt (starve_cnt)
  );

  // Grants are purely combinational so that accept = req & gnt in the same cycle.
  always_comb begin
    force_fetch = bus.if_req & (starve_cnt == STARVE_LIM);
    dm_gnt_c    = ~rst & bus.dm_req & ~force_fetch;
    if_gnt_c    = ~rst & bus.if_req & ~dm_gnt_c;
    starve_inc  = bus.if_req & ~if_gnt_c;
    starve_clr  = ~bus.if_req | if_gnt_c;
  end

  always_comb begin
    addr_d  = addr_q;
    state_d = ST_IDLE;
    if (rst) begin
      addr_d = '0;
    end else if (dm_gnt_c) begin
      addr_d  = bus.dm_addr;
      state_d = bus.dm_we ? ST_DWRITE : ST_DREAD;
    end else if (if_gnt_c) begin
      addr_d  = bus.if_addr;
      state_d = ST_FETCH;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign fetch_rsp = (state_q == ST_FETCH);
  assign dread_rsp = (state_q == ST_DREAD);

  assign bus.if_gnt    = if_gnt_c;
  assign bus.dm_gnt    = dm_gnt_c;
  assign bus.mem_addr  = addr_d;
  assign bus.mem_we    = dm_gnt_c & bus.dm_we;
  assign bus.mem_wdata = dm_gnt_c ? bus.dm_wdata : ZERO_D;
  assign bus.if_valid  = fetch_rsp;
  assign bus.if_rdata  = fetch_rsp ? bus.mem_rdata : ZERO_D;
  assign bus.dm_valid  = dread_rsp;
  assign bus.dm_rdata  = dread_rsp ? bus.mem_rdata : ZERO_D;
  assign bus.stall     = ~rst & ((bus.if_req & ~if_gnt_c) | (bus.dm_req & ~dm_gnt_c));

  a_one_grant : assert property (@(posedge clk) disable iff (rst) !(if_gnt_c && dm_gnt_c));
  a_we_gnt    : assert property (@(posedge clk) disable iff (rst) bus.mem_we |-> dm_gnt_c);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a cycle-level reference model and memory.
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  mem_port_arbiter_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  mem_port_arbiter #(
    .DATA_W     (16),
    .ADDR_W     (16),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical memory seen by the DUT and an independent shadow used by the model.
  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pend is the response owed this cycle (0 none, 1 fetch, 2 read, 3 write).
  int          starve    = 0;
  int          pend      = 0;
  logic [15:0] pend_addr = '0;
  logic [15:0] last_addr = '0;

  always @(negedge clk) begin : model
    logic        e_dm, e_if, e_stall, e_we;
    logic [15:0] e_addr;
    if (rst) begin
      check("rst_ctrl", {26'b0, bus.if_gnt, bus.dm_gnt, bus.if_valid, bus.dm_valid,
                         bus.mem_we, bus.stall}, 32'd0);
      check("rst_addr", {16'b0, bus.mem_addr}, 32'd0);
      check("rst_rdata", {bus.if_rdata, bus.dm_rdata}, 32'd0);
      starve    = 0;
      pend      = 0;
      last_addr = '0;
    end else begin
      e_dm    = bus.dm_req && !(bus.if_req && starve >= STARVE_MAX);
      e_if    = bus.if_req && !e_dm;
      e_stall = (bus.if_req && !e_if) || (bus.dm_req && !e_dm);
      e_we    = e_dm && bus.dm_we;
      e_addr  = e_dm ? bus.dm_addr : (e_if ? bus.if_addr : last_addr);
      check("m_gnt", {30'b0, bus.if_gnt, bus.dm_gnt}, {30'b0, e_if, e_dm});
      check("m_stall", {31'b0, bus.stall}, {31'b0, e_stall});
      check("m_we", {31'b0, bus.mem_we}, {31'b0, e_we});
      check("m_addr", {16'b0, bus.mem_addr}, {16'b0, e_addr});
      if (e_we) check("m_wdata", {16'b0, bus.mem_wdata}, {16'b0, bus.dm_wdata});
      check("m_if_valid", {31'b0, bus.if_valid}, {31'b0, pend == 1});
      check("m_if_rdata", {16'b0, bus.if_rdata}, {16'b0, (pend == 1) ? ref_mem[pend_addr] : 16'h0});
      check("m_dm_valid", {31'b0, bus.dm_valid}, {31'b0, pend == 2});
      check("m_dm_rdata", {16'b0, bus.dm_rdata}, {16'b0, (pend == 2) ? ref_mem[pend_addr] : 16'h0});
      if (e_we) ref_mem[bus.dm_addr] = bus.dm_wdata;
      pend      = e_dm ? (bus.dm_we ? 3 : 2) : (e_if ? 1 : 0);
      pend_addr = e_addr;
      starve    = (bus.if_req && !e_if) ? ((starve < STARVE_MAX) ? starve + 1 : starve) : 0;
      last_addr = e_addr;
    end
  end

  task automatic drive(input logic ir, input logic [15:0] ia, input logic dr,
                       input logic dw, input logic [15:0] da, input logic [15:0] dd);
    @(posedge clk);
    #1;
    bus.if_req   = ir;
    bus.if_addr  = ia;
    bus.dm_req   = dr;
    bus.dm_we    = dw;
    bus.dm_addr  = da;
    bus.dm_wdata = dd;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  logic [15:0] lit_f [4];
  logic [5:0]  starve_pat;

  initial begin
    lit_f      = '{16'h1000, 16'h1003, 16'h1006, 16'h1009};
    starve_pat = 6'b101111;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 16'(i * 3 + 'h1000);
      ref_mem[i] = 16'(i * 3 + 'h1000);
    end
    rst          = 1'b1;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.dm_req   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
    repeat (3) @(negedge clk);
    check("lit_rst_stall", {31'b0, bus.stall}, 32'd0);
    check("lit_rst_state", {30'b0, dut.state_q}, 32'd0);

    idle();
    rst = 1'b0;

    // Fetch-only stream, one per cycle
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'(i), 1'b0, 1'b0, 16'h0, 16'h0);
      @(negedge clk);
      check("lit_fetch_gnt", {31'b0, bus.if_gnt}, 32'd1);
      check("lit_fetch_stall", {31'b0, bus.stall}, 32'd0);
      if (i > 0) check("lit_fetch_data", {16'b0, bus.if_rdata}, {16'b0, lit_f[i-1]});
    end
    idle();
    @(negedge clk);
    check("lit_fetch_last", {16'b0, bus.if_rdata}, {16'b0, lit_f[3]});

    // Conflict: data wins
    drive(1'b1, 16'h0010, 1'b1, 1'b0, 16'h03E7, 16'h0);
    @(negedge clk);
    check("lit_conf_gnt", {29'b0, bus.dm_gnt, bus.if_gnt, bus.stall}, 32'b101);
    idle();
    @(negedge clk);
    check("lit_conf_valid", {31'b0, bus.dm_valid}, 32'd1);
    check("lit_conf_rdata", {16'b0, bus.dm_rdata}, 32'h1BB5);

    // Starvation: fetch forced in the fifth cycle
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 16'h0020, 1'b1, 1'b0, 16'(16'h0010 + k), 16'h0);
      @(negedge clk);
      check("lit_starve_dm", {31'b0, bus.dm_gnt}, {31'b0, starve_pat[k]});
      check("lit_starve_if", {31'b0, bus.if_gnt}, {31'b0, ~starve_pat[k]});
    end

    // Write then read at the top address
    drive(1'b0, 16'h0, 1'b1, 1'b1, 16'hFFFF, 16'hBEEF);
    @(negedge clk);
    check("lit_wr_we", {31'b0, bus.mem_we}, 32'd1);
    check("lit_wr_addr", {16'b0, bus.mem_addr}, 32'hFFFF);
    check("lit_wr_data", {16'b0, bus.mem_wdata}, 32'hBEEF);
    drive(1'b0, 16'h0, 1'b1, 1'b0, 16'hFFFF, 16'h0);
    @(negedge clk);
    check("lit_wr_novalid", {30'b0, bus.dm_valid, bus.mem_we}, 32'd0);
    idle();
    @(negedge clk);
    check("lit_rd_valid", {31'b0, bus.dm_valid}, 32'd1);
    check("lit_rd_data", {16'b0, bus.dm_rdata}, 32'hBEEF);

    // Reset in the cycle after a read grant, with requests held
    drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0002, 16'h0);
    drive(1'b1, 16'h0030, 1'b1, 1'b0, 16'h0040, 16'h0);
    rst = 1'b1;
    @(negedge clk);
    check("lit_rst_mid", {27'b0, bus.dm_valid, bus.dm_gnt, bus.if_gnt, bus.stall, bus.mem_we}, 32'd0);
    check("lit_rst_maddr", {16'b0, bus.mem_addr}, 32'd0);
    drive(1'b1, 16'h0005, 1'b0, 1'b0, 16'h0, 16'h0);
    rst = 1'b0;
    @(negedge clk);
    check("lit_post_rst", {30'b0, bus.if_gnt, bus.dm_valid}, 32'b10);
    idle();
    @(negedge clk);
    check("lit_post_fetch", {16'b0, bus.if_rdata}, 32'h100F);

    // Idle
    repeat (3) begin
      idle();
      @(negedge clk);
      check("lit_idle", {27'b0, bus.mem_we, bus.if_valid, bus.dm_valid, bus.stall, bus.if_gnt}, 32'd0);
      check("lit_idle_state", {30'b0, dut.state_q}, 32'd0);
      check("lit_idle_addr", {16'b0, bus.mem_addr}, 32'h0005);
    end

    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
